// File: rtl/hex_display_scheduler_if.sv
// Request/grant bundle between the display requesters and the scheduler.
// Requesters drive req/data; the scheduler returns ack, busy and the current owner.
interface hex_display_scheduler_if;
   logic [1:0]  req;
   logic [23:0] data0;
   logic [23:0] data1;
   logic [1:0]  ack;
   logic        busy;
   logic        owner;

   modport master (output req, data0, data1, input ack, busy, owner);
   modport slave  (input req, data0, data1, output ack, busy, owner);
endinterface

// File: rtl/hex_display_scheduler.sv
// Round-robin grant of two six-digit hex values onto a shared 7-segment decoder.
// Digits are staged one per cycle and committed to the outputs in a single edge.
//
// state | meaning
// IDLE  | waiting for a request; grants on the next edge if any req bit is high
// SCAN  | decoding the shadow value one digit per cycle, commit at cnt==5
module hex_display_scheduler #(
   parameter bit LZ_DEFAULT = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   hex_display_scheduler_if.slave bus,
   input  logic                   lz_override,
   input  logic                   lz_en,
   output logic [6:0]             hex0,
   output logic [6:0]             hex1,
   output logic [6:0]             hex2,
   output logic [6:0]             hex3,
   output logic [6:0]             hex4,
   output logic [6:0]             hex5
);

   typedef enum logic {IDLE, SCAN} state_t;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   state_t      state;
   logic [2:0]  cnt;
   logic [23:0] shadow;
   logic [1:0]  ack_q;
   logic        owner_q;
   logic        last_gnt;
   logic [6:0]  stage [0:4];
   logic [6:0]  hex_q [0:5];

   logic [3:0]  nib;
   logic [6:0]  seg;
   logic        gnt;
   logic        lz_on;
   logic [5:1]  blank;

   always_comb begin
      nib = shadow[3:0];
      case (cnt)
         3'd1:    nib = shadow[7:4];
         3'd2:    nib = shadow[11:8];
         3'd3:    nib = shadow[15:12];
         3'd4:    nib = shadow[19:16];
         3'd5:    nib = shadow[23:20];
         default: nib = shadow[3:0];
      endcase
   end

   // The only hex decoder in the block; shared by all six digits over time.
   always_comb begin
      seg = SEG_OFF;
      case (nib)
         4'h0: seg = 7'b1000000;
         4'h1: seg = 7'b1111001;
         4'h2: seg = 7'b0100100;
         4'h3: seg = 7'b0110000;
         4'h4: seg = 7'b0011001;
         4'h5: seg = 7'b0010010;
         4'h6: seg = 7'b0000010;
         4'h7: seg = 7'b1111000;
         4'h8: seg = 7'b0000000;
         4'h9: seg = 7'b0010000;
         4'hA: seg = 7'b0001000;
         4'hB: seg = 7'b0000011;
         4'hC: seg = 7'b1000110;
         4'hD: seg = 7'b0100001;
         4'hE: seg = 7'b0000110;
         4'hF: seg = 7'b0001110;
         default: seg = SEG_OFF;
      endcase
   end

   always_comb begin
      gnt      = (bus.req == 2'b11) ? ~last_gnt : bus.req[1];
      lz_on    = lz_override ? lz_en : LZ_DEFAULT;
      blank[1] = lz_on && (shadow[23:4]  == 20'd0);
      blank[2] = lz_on && (shadow[23:8]  == 16'd0);
      blank[3] = lz_on && (shadow[23:12] == 12'd0);
      blank[4] = lz_on && (shadow[23:16] == 8'd0);
      blank[5] = lz_on && (shadow[23:20] == 4'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 3'd0;
         shadow   <= 24'd0;
         ack_q    <= 2'b00;
         owner_q  <= 1'b0;
         last_gnt <= 1'b1;
         for (int i = 0; i < 5; i++) stage[i] <= SEG_OFF;
         for (int i = 0; i < 6; i++) hex_q[i] <= SEG_OFF;
      end else begin
         ack_q <= 2'b00;
         case (state)
            IDLE: begin
               if (bus.req != 2'b00) begin
                  shadow   <= gnt ? bus.data1 : bus.data0;
                  ack_q    <= gnt ? 2'b10 : 2'b01;
                  last_gnt <= gnt;
                  cnt      <= 3'd0;
                  state    <= SCAN;
               end
            end
            SCAN: begin
               if (cnt < 3'd5) begin
                  stage[cnt] <= seg;
                  cnt        <= cnt + 3'd1;
               end else if (cnt == 3'd5) begin
                  // Digit 5 bypasses staging so all six land on this edge.
                  hex_q[0] <= stage[0];
                  for (int i = 1; i < 5; i++)
                     hex_q[i] <= blank[i] ? SEG_OFF : stage[i];
                  hex_q[5] <= blank[5] ? SEG_OFF : seg;
                  owner_q  <= last_gnt;
                  state    <= IDLE;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.ack   = ack_q;
   assign bus.busy  = (state == SCAN);
   assign bus.owner = owner_q;
   assign hex0 = hex_q[0];
   assign hex1 = hex_q[1];
   assign hex2 = hex_q[2];
   assign hex3 = hex_q[3];
   assign hex4 = hex_q[4];
   assign hex5 = hex_q[5];

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Directed bench for hex_display_scheduler: every cycle checks ack, busy, owner
// and all six digits against hand-computed expectations.
module tb_hex_display_scheduler;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S8 = 7'b0000000;
   localparam logic [6:0] SA = 7'b0001000;
   localparam logic [6:0] SB = 7'b0000011;
   localparam logic [6:0] SD = 7'b0100001;
   localparam logic [6:0] SE = 7'b0000110;
   localparam logic [6:0] SF = 7'b0001110;
   localparam logic [6:0] BL = 7'b1111111;

   logic       clk = 1'b0;
   logic       reset;
   logic       lz_override;
   logic       lz_en;
   logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;

   int checks = 0;
   int errors = 0;

   logic [6:0] disp [0:5];
   logic       exp_owner;

   hex_display_scheduler_if bus ();

   hex_display_scheduler #(.LZ_DEFAULT(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .lz_override (lz_override),
      .lz_en       (lz_en),
      .hex0        (hex0),
      .hex1        (hex1),
      .hex2        (hex2),
      .hex3        (hex3),
      .hex4        (hex4),
      .hex5        (hex5)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_disp(input logic [41:0] v);
      for (int i = 0; i < 6; i++) disp[i] = v[7*i +: 7];
   endtask

   // One clock edge, then every observable output is compared.
   task automatic step(input string tag, input logic [1:0] eack, input logic ebusy);
      @(posedge clk);
      #1;
      chk({tag, " ack"},   {30'd0, bus.ack}, {30'd0, eack});
      chk({tag, " busy"},  {31'd0, bus.busy}, {31'd0, ebusy});
      chk({tag, " owner"}, {31'd0, bus.owner}, {31'd0, exp_owner});
      chk({tag, " hex0"},  {25'd0, hex0}, {25'd0, disp[0]});
      chk({tag, " hex1"},  {25'd0, hex1}, {25'd0, disp[1]});
      chk({tag, " hex2"},  {25'd0, hex2}, {25'd0, disp[2]});
      chk({tag, " hex3"},  {25'd0, hex3}, {25'd0, disp[3]});
      chk({tag, " hex4"},  {25'd0, hex4}, {25'd0, disp[4]});
      chk({tag, " hex5"},  {25'd0, hex5}, {25'd0, disp[5]});
   endtask

   // Full E0..E6 scan; req is dropped after E0 unless hold is set.
   task automatic scan(input string tag, input logic [1:0] eack, input logic hold,
                       input logic [41:0] edisp, input logic eown);
      step({tag, " E0"}, eack, 1'b1);
      if (!hold) bus.req = 2'b00;
      for (int k = 1; k <= 5; k++) step({tag, " mid"}, 2'b00, 1'b1);
      set_disp(edisp);
      exp_owner = eown;
      step({tag, " E6"}, 2'b00, 1'b0);
   endtask

   initial begin
      reset       = 1'b1;
      lz_override = 1'b0;
      lz_en       = 1'b0;
      bus.req     = 2'b00;
      bus.data0   = 24'd0;
      bus.data1   = 24'd0;
      set_disp({BL, BL, BL, BL, BL, BL});
      exp_owner = 1'b0;

      step("reset", 2'b00, 1'b0);
      step("reset", 2'b00, 1'b0);
      reset = 1'b0;
      step("idle", 2'b00, 1'b0);

      // Basic request with leading-zero blanking.
      bus.data0 = 24'h000123;
      bus.req   = 2'b01;
      scan("c1", 2'b01, 1'b0, {BL, BL, BL, S1, S2, S3}, 1'b0);

      // Requester 1, blanking forced off.
      lz_override = 1'b1;
      lz_en       = 1'b0;
      bus.data1   = 24'hF0A800;
      bus.req     = 2'b10;
      scan("c3", 2'b10, 1'b0, {SF, S0, SA, S8, S0, S0}, 1'b1);

      // Both requesting continuously: 0,1,0,1 with grants 7 cycles apart.
      lz_override = 1'b0;
      bus.data0   = 24'h000005;
      bus.data1   = 24'h0000E0;
      bus.req     = 2'b11;
      scan("rr0", 2'b01, 1'b1, {BL, BL, BL, BL, BL, S5}, 1'b0);
      scan("rr1", 2'b10, 1'b1, {BL, BL, BL, BL, SE, S0}, 1'b1);
      scan("rr2", 2'b01, 1'b1, {BL, BL, BL, BL, BL, S5}, 1'b0);
      scan("rr3", 2'b10, 1'b1, {BL, BL, BL, BL, SE, S0}, 1'b1);
      bus.req = 2'b00;
      step("rr idle", 2'b00, 1'b0);

      // Zero value: only digit 0 lit.
      bus.data0 = 24'd0;
      bus.req   = 2'b01;
      scan("zero", 2'b01, 1'b0, {BL, BL, BL, BL, BL, S0}, 1'b0);

      // Data changed mid-scan must not leak into the commit.
      bus.req = 2'b01;
      step("snap E0", 2'b01, 1'b1);
      bus.req = 2'b00;
      step("snap E1", 2'b00, 1'b1);
      step("snap E2", 2'b00, 1'b1);
      bus.data0 = 24'h654321;
      step("snap E3", 2'b00, 1'b1);
      step("snap E4", 2'b00, 1'b1);
      step("snap E5", 2'b00, 1'b1);
      step("snap E6", 2'b00, 1'b0);

      // Request from 0 raised mid-scan of 1 waits until E7.
      bus.data1 = 24'h000B1D;
      bus.data0 = 24'h000042;
      bus.req   = 2'b10;
      step("late E0", 2'b10, 1'b1);
      bus.req = 2'b00;
      step("late E1", 2'b00, 1'b1);
      step("late E2", 2'b00, 1'b1);
      bus.req = 2'b01;
      step("late E3", 2'b00, 1'b1);
      step("late E4", 2'b00, 1'b1);
      step("late E5", 2'b00, 1'b1);
      set_disp({BL, BL, BL, SB, S1, SD});
      exp_owner = 1'b1;
      step("late E6", 2'b00, 1'b0);
      scan("late2", 2'b01, 1'b0, {BL, BL, BL, BL, S4, S2}, 1'b0);

      // Reset in the middle of a scan blanks the display and aborts the grant.
      bus.data0 = 24'h000077;
      bus.req   = 2'b01;
      step("abort E0", 2'b01, 1'b1);
      bus.req = 2'b00;
      step("abort E1", 2'b00, 1'b1);
      step("abort E2", 2'b00, 1'b1);
      reset = 1'b1;
      set_disp({BL, BL, BL, BL, BL, BL});
      exp_owner = 1'b0;
      step("abort E3", 2'b00, 1'b0);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) step("post abort", 2'b00, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
